// File: rtl/oh_arb_dffq.sv
// oh_arb_dffq: round-robin arbiter that feeds N requesters into one shared DW-wide output register.
// Optional requester lock (sticky grant) is built when OH_ARB_DFFQ_LOCK_EN is defined.
//
// Lock FSM (only with OH_ARB_DFFQ_LOCK_EN):
//   state   | meaning
//   LK_OPEN | normal round-robin, any requester may win
//   LK_HELD | only owner_q may win; pointer frozen until owner releases
module oh_arb_dffq #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
`ifdef OH_ARB_DFFQ_LOCK_EN
  input  logic [N-1:0]    in_lock,
`endif
  output logic [N-1:0]    in_ready,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_id
);

  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [IW-1:0] out_id_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  logic [N-1:0]  elig;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan_idx;
  logic [N-1:0]  grant_oh;
  logic [DW-1:0] win_data;
  logic          load_en;
  logic          xfer;
  logic          ptr_hold;

  assign load_en = ~out_valid_q | out_ready;

  // Scan pointer, pointer+1, ... wrapping at N (N need not be a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N)) begin
        scan_idx = scan_idx - (IW+1)'(N);
      end
      if (!win_found && elig[scan_idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[win_idx] = 1'b1;
  end

  assign win_data = in_data[win_idx*DW +: DW];
  assign xfer     = win_found & load_en & ~reset;
  assign in_ready = xfer ? grant_oh : '0;

  always_comb begin
    if (win_idx == IW'(N-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx + 1'b1;
    end
  end

`ifdef OH_ARB_DFFQ_LOCK_EN
  typedef enum logic {LK_OPEN, LK_HELD} lock_state_t;

  lock_state_t   lock_state_q, lock_state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  owner_oh;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // While held, the owner is the only candidate even if it is not requesting.
  assign elig = (lock_state_q == LK_HELD) ? (in_valid & owner_oh) : in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_q <= LK_OPEN;
      owner_q      <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    ptr_hold     = 1'b0;
    case (lock_state_q)
      LK_OPEN: begin
        if (xfer && in_lock[win_idx]) begin
          lock_state_d = LK_HELD;
          owner_d      = win_idx;
          ptr_hold     = 1'b1;
        end
      end
      LK_HELD: begin
        if (xfer) begin
          if (in_lock[win_idx]) begin
            ptr_hold = 1'b1;
          end else begin
            lock_state_d = LK_OPEN;
          end
        end
      end
      default: lock_state_d = LK_OPEN;
    endcase
  end
`else
  assign elig     = in_valid;
  assign ptr_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= win_data;
      out_id_q    <= win_idx;
      if (!ptr_hold) begin
        ptr_q <= ptr_d;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_oh_arb_dffq.sv
// Testbench for oh_arb_dffq: directed literal checks plus randomized traffic against a behavioural model.
// Lock scenarios run only when OH_ARB_DFFQ_LOCK_EN is defined.
module tb_oh_arb_dffq;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_lock;
  logic [N-1:0]    in_ready;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;

  int n_checks = 0;
  int n_errors = 0;

  oh_arb_dffq #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef OH_ARB_DFFQ_LOCK_EN
    .in_lock   (in_lock),
`endif
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'hA0 + i;
  endtask

  // Behavioural model: stage contents, rotating priority pointer, lock owner.
  logic          m_init = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_ptr;
  logic          m_locked;
  int            m_owner;
  int            m_win;
  int            m_j;
  logic          m_load;
  logic [N-1:0]  m_rdy;

  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_id", 64'(out_id), 64'(m_id));
    end
    if (reset) begin
      if (m_init) chk("in_ready_rst", 64'(in_ready), 64'(0));
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
      m_locked = 1'b0; m_owner = 0; m_init = 1'b1;
    end else if (m_init) begin
      m_load = !m_valid || out_ready;
      m_win = -1;
      if (m_locked) begin
        if (in_valid[m_owner]) m_win = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          m_j = (m_ptr + k) % N;
          if (m_win < 0 && in_valid[m_j]) m_win = m_j;
        end
      end
      m_rdy = '0;
      if (m_win >= 0 && m_load) m_rdy[m_win] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      if (m_win >= 0 && m_load) begin
        m_valid = 1'b1;
        m_data  = in_data[m_win*DW +: DW];
        m_id    = m_win;
        if (in_lock[m_win]) begin
          m_locked = 1'b1;
          m_owner  = m_win;
        end else begin
          m_locked = 1'b0;
          m_ptr    = (m_win + 1) % N;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_lock = '0;
    set_dir_data();

    // Reset held two cycles with all requesting
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_id", 64'(out_id), 64'(0));
    reset = 1'b0;
    #1;
    chk("first_grant", 64'(in_ready), 64'(4'b0001));

    // Rotation 0,1,2,3,0,1 with no bubbles
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rot_valid", 64'(out_valid), 64'(1));
      chk("rot_id", 64'(out_id), 64'(k % 4));
      chk("rot_data", 64'(out_data), 64'(32'hA0 + (k % 4)));
    end

    // Backpressure then same-cycle drain+load
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    step();
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_data", 64'(out_data), 64'(32'hA1));
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(in_ready), 64'(4'b0100));
    step();
    chk("bp_reload_valid", 64'(out_valid), 64'(1));
    chk("bp_reload_id", 64'(out_id), 64'(2));

    // Sparse/wrap: pointer is 3, only requester 1
    in_valid = 4'b0010;
    step();
    chk("wrap_id", 64'(out_id), 64'(1));
    in_valid = 4'b0101;
    step();
    chk("wrap_next_id", 64'(out_id), 64'(2));

    // Steer pointer to 2, then reset mid-stream
    in_valid = 4'b0001;
    step();
    in_valid = 4'b0010;
    step();
    chk("pre_rst_id", 64'(out_id), 64'(1));
    in_valid = 4'b1111;
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    reset = 1'b0;
    step();
    chk("post_rst_id", 64'(out_id), 64'(0));

`ifdef OH_ARB_DFFQ_LOCK_EN
    step();
    chk("pre_lock_id", 64'(out_id), 64'(1));
    in_lock = 4'b0100;
    step();
    chk("lock_id", 64'(out_id), 64'(2));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("locked_id", 64'(out_id), 64'(2));
    end
    in_valid = 4'b1011;
    #1;
    chk("locked_owner_idle", 64'(in_ready), 64'(0));
    in_valid = 4'b1111;
    in_lock = 4'b0000;
    step();
    chk("unlock_id", 64'(out_id), 64'(2));
    step();
    chk("after_unlock_id", 64'(out_id), 64'(3));
`endif

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
`ifdef OH_ARB_DFFQ_LOCK_EN
      in_lock = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
`endif
    end
    reset = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oh_arb_dffq.md
Name: oh_arb_dffq

Overview:
- Round-robin arbiter and sequencer for one shared DW-wide positive-edge D-flop stage.
- N requesters compete for the stage.
- The winner's data is captured into the output register with a valid/ready handshake.
- Used wherever several producers share one pipeline register, for example a mesh egress slot or a shared config bus.

Parameters:
- N, 4, number of requesters (2..16).
- DW, 32, data width per requester.
- IW, $clog2(N), width of the winner index.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, N, per-requester request/valid.
- in_data, input, N*DW, requester i occupies bits [i*DW +: DW].
- in_ready, output, N, one-hot or zero; requester i transfers when in_valid[i] & in_ready[i].
- out_valid, output, 1, output register holds data.
- out_data, output, DW, registered data.
- out_id, output, IW, index of the requester that produced out_data.
- out_ready, input, 1, downstream accepts; transfer when out_valid & out_ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, sampled on the clk edge: out_valid=0, out_data=0, out_id=0, pointer=0 (requester 0 highest priority), lock state cleared.
- Combinational in_ready stays 0 while reset is high.
- load_en = ~out_valid | out_ready. The stage accepts new data when empty or being drained in the same cycle.
- Arbitration is combinational on in_valid and pointer.
  - The winner is the first i with in_valid[i]=1, scanning pointer, pointer+1, ... modulo N.
  - in_ready[winner] = load_en; every other in_ready bit = 0.
- in_ready never depends on in_data. It may depend on in_valid and out_ready (single-cycle combinational path).
- On an input transfer at edge t:
  - out_data <= winner data, out_id <= winner, out_valid <= 1.
  - pointer <= (winner+1) mod N, with wrap from N-1 to 0.
- Latency: data accepted at edge t is visible on out_data after edge t. Full throughput of 1 transfer per cycle when out_ready=1.
- Output drain with no input transfer: out_valid <= 0. out_data and out_id hold their last value.
- out_valid=1 & out_ready=0: register holds, all in_ready=0, pointer holds.
- No requests: pointer holds, no grant.
- Simultaneous drain and load in one cycle: the new value replaces the old. out_valid stays 1 with no bubble.
- Fairness:
  - A requester holding in_valid=1 is granted within N transfers.
  - After a grant, a requester has lowest priority.
- in_valid may drop without a transfer. The arbiter re-evaluates every cycle; there is no sticky grant except under lock.
- Reset asserted mid-stream: the pending output is discarded (out_valid=0 on the next edge) and the pointer returns to 0.

Optional Feature:
- Macro: OH_ARB_DFFQ_LOCK_EN.
- Defined:
  - Adds port in_lock, input, N.
  - A transfer from requester i with in_lock[i]=1 sets locked=1, owner=i, and the pointer does not advance.
  - While locked, only the owner can win; in_ready for others = 0, even if the owner's in_valid=0.
  - Lock is released on a transfer from the owner with in_lock[owner]=0. The pointer then becomes owner+1 mod N.
  - Reset clears the lock.
- Not defined: port absent, pure round-robin as above, no lock state.

Test Plan:
- Reset check: assert reset 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_id=0, in_ready=0. First grant after release goes to requester 0.
- Round-robin rotation: in_valid=4'b1111, out_ready=1, in_data[i]=32'hA0+i.
  - out_id sequence 0,1,2,3,0,1 on consecutive cycles.
  - out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0.
  - No bubbles after the first load.
- Backpressure: out_ready=0 after one transfer -> out_valid stays 1, out_data stable, in_ready=0. Raising out_ready yields a same-cycle drain+load with out_valid continuous.
- Sparse/wrap: pointer=3 with only in_valid[1]=1 -> requester 1 wins, pointer becomes 2. Next cycle in_valid=4'b0101 -> requester 2 wins.
- Reset mid-operation: out_valid=1, pointer=2, assert reset for one cycle -> out_valid=0. The next grant with in_valid=4'b1111 is requester 0.
- Lock (with OH_ARB_DFFQ_LOCK_EN): requester 2 transfers with in_lock[2]=1 while in_valid=4'b1111.
  - Next 3 transfers are all out_id=2.
  - After a transfer with in_lock[2]=0, the following grant is requester 3.
